// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM states, region decode
// constants and default widths.
package mem_bus_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int RAM_AW_DEF = 7;

    localparam logic [3:0] REGION_RAM = 4'h0;
    localparam logic [3:0] REGION_LED = 4'h1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_LED  = 2'd1,
        RGN_NONE = 2'd2
    } region_t;

    // Maps the top nibble of a bus address onto the region it selects.
    function automatic region_t decode_region(input logic [3:0] page);
        region_t rgn;
        rgn = RGN_NONE;
        if (page == REGION_RAM) begin
            rgn = RGN_RAM;
        end else if (page == REGION_LED) begin
            rgn = RGN_LED;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin pick: ptr names the port favoured on a tie; the
// winner's opposite becomes favoured next.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       next_ptr
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        gnt      = 2'b00;
        next_ptr = ptr;
        case (req)
            2'b01: begin
                gnt      = 2'b01;
                next_ptr = 1'b1;
            end
            2'b10: begin
                gnt      = 2'b10;
                next_ptr = 1'b0;
            end
            2'b11: begin
                gnt      = ptr ? 2'b10 : 2'b01;
                next_ptr = ~ptr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter in front of a synchronous RAM plus a memory-mapped LED
// register; fixed-latency reads, round-robin between processor and loader.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RAM_AW = RAM_AW_DEF
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [1:0]        Req,
    input  logic [1:0]        We,
    input  logic [15:0]       Addr0,
    input  logic [15:0]       Addr1,
    input  logic [DATA_W-1:0] Wdata0,
    input  logic [DATA_W-1:0] Wdata1,
    output logic [1:0]        Gnt,
    output logic [1:0]        Rvalid,
    output logic [DATA_W-1:0] Rdata,
    output logic [RAM_AW-1:0] MemAddr,
    output logic              MemWren,
    output logic [DATA_W-1:0] MemData,
    input  logic [DATA_W-1:0] MemQ,
    output logic [DATA_W-1:0] LedOut
);

    state_t              state;
    logic                rr_ptr;
    logic [1:0]          pick;
    logic                pick_next_ptr;

    logic                port_q;
    logic                we_q;
    region_t             region_q;
    logic [RAM_AW-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [15:0]         win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_we;
    logic                unused_addr_mid;

    rr_pick2 u_pick (
        .req      (Req),
        .ptr      (rr_ptr),
        .gnt      (pick),
        .next_ptr (pick_next_ptr)
    );

    assign win_addr  = pick[1] ? Addr1  : Addr0;
    assign win_wdata = pick[1] ? Wdata1 : Wdata0;
    assign win_we    = We[pick[1]];

    // Address bits between the RAM index and the region nibble do not
    // select anything, which is what makes RAM accesses alias.
    assign unused_addr_mid = ^win_addr[11:RAM_AW];

    // Derived straight from state so that an asynchronous reset drops the
    // write strobe immediately instead of waiting for a clock edge.
    assign MemAddr = ram_addr_q;
    assign MemData = wdata_q;
    assign MemWren = (state == ST_ACCESS) && we_q && (region_q == RGN_RAM);

    // NOTE: all state here is updated with non-blocking assignments so that
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= ST_IDLE;
            rr_ptr     <= 1'b0;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            region_q   <= RGN_NONE;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            Gnt        <= 2'b00;
            Rvalid     <= 2'b00;
            Rdata      <= '0;
            LedOut     <= '0;
        end else begin
            Gnt    <= 2'b00;
            Rvalid <= 2'b00;

            case (state)
                ST_IDLE: begin
                    if (|Req) begin
                        port_q     <= pick[1];
                        we_q       <= win_we;
                        region_q   <= decode_region(win_addr[15:12]);
                        ram_addr_q <= win_addr[RAM_AW-1:0];
                        wdata_q    <= win_wdata;
                        Gnt        <= pick;
                        rr_ptr     <= pick_next_ptr;
                        state      <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (we_q) begin
                        if (region_q == RGN_LED) begin
                            LedOut <= wdata_q;
                        end
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RDWAIT;
                    end
                end

                ST_RDWAIT: begin
                    // Every region takes this same path so read latency is
                    // independent of the address.
                    case (region_q)
                        RGN_RAM: Rdata <= MemQ;
                        RGN_LED: Rdata <= LedOut;
                        default: Rdata <= '0;
                    endcase
                    state <= ST_RETURN;
                end

                ST_RETURN: begin
                    Rvalid <= port_q ? 2'b10 : 2'b01;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a transaction-level model predicts
// every output each cycle, and directed scenarios pin hand-computed values.
module tb_mem_bus_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int DEPTH = 4096;

    logic           Clock = 1'b0;
    logic           Resetn;
    logic [1:0]     Req;
    logic [1:0]     We;
    logic [15:0]    Addr0, Addr1;
    logic [DW-1:0]  Wdata0, Wdata1;
    logic [1:0]     Gnt, Rvalid;
    logic [DW-1:0]  Rdata, MemData, LedOut;
    logic [DW-1:0]  MemQ = '0;
    logic [AW-1:0]  MemAddr;
    logic           MemWren;

    mem_bus_arbiter #(.DATA_W(DW), .RAM_AW(AW)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Req     (Req),
        .We      (We),
        .Addr0   (Addr0),
        .Addr1   (Addr1),
        .Wdata0  (Wdata0),
        .Wdata1  (Wdata1),
        .Gnt     (Gnt),
        .Rvalid  (Rvalid),
        .Rdata   (Rdata),
        .MemAddr (MemAddr),
        .MemWren (MemWren),
        .MemData (MemData),
        .MemQ    (MemQ),
        .LedOut  (LedOut)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous RAM attached to the memory port: data one clock after the address.
    logic [DW-1:0] env_ram [int];
    always @(posedge Clock) begin
        MemQ <= env_ram.exists(int'(MemAddr)) ? env_ram[int'(MemAddr)] : '0;
        if (MemWren === 1'b1) env_ram[int'(MemAddr)] = MemData;
    end

    // Transaction-level model. A transaction accepted at edge t shows Gnt and
    // the RAM write strobe after t, a LED write after t+1, read data after
    // t+2 and the read-valid pulse after t+3; the bus is free again at t+2
    // for writes and t+4 for reads.
    typedef struct packed {
        logic [1:0]    gnt;
        logic [1:0]    rv;
        logic          wren;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mdata;
    } exp_t;

    exp_t          exp_q [DEPTH];
    logic [DW-1:0] ref_ram [int];
    logic [DW-1:0] m_led, m_rdata, led_new, rd_new;
    int            free_at, led_at, rd_at, last_port;
    int            mp;
    logic [15:0]   ma;
    logic [DW-1:0] md;
    logic          mw;
    logic [AW-1:0] mi;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) exp_q[i] = '0;
            last_port = 1;
            m_led     = '0;
            m_rdata   = '0;
            free_at   = 0;
            led_at    = -1;
            rd_at     = -1;
        end else begin
            cyc++;
            if (led_at == cyc) m_led = led_new;
            if (rd_at == cyc) m_rdata = rd_new;
            if (cyc + 3 < DEPTH && cyc >= free_at && Req != 2'b00) begin
                mp        = (Req == 2'b11) ? 1 - last_port : (Req[1] ? 1 : 0);
                last_port = mp;
                ma        = (mp == 1) ? Addr1 : Addr0;
                md        = (mp == 1) ? Wdata1 : Wdata0;
                mw        = We[mp];
                mi        = ma[AW-1:0];
                exp_q[cyc].gnt = (mp == 1) ? 2'b10 : 2'b01;
                if (mw) begin
                    if (ma[15:12] == 4'h0) begin
                        exp_q[cyc].wren  = 1'b1;
                        exp_q[cyc].maddr = mi;
                        exp_q[cyc].mdata = md;
                        ref_ram[int'(mi)] = md;
                    end else if (ma[15:12] == 4'h1) begin
                        led_at  = cyc + 1;
                        led_new = md;
                    end
                    free_at = cyc + 2;
                end else begin
                    if (ma[15:12] == 4'h0)
                        rd_new = ref_ram.exists(int'(mi)) ? ref_ram[int'(mi)] : '0;
                    else if (ma[15:12] == 4'h1)
                        rd_new = m_led;
                    else
                        rd_new = '0;
                    rd_at = cyc + 2;
                    exp_q[cyc + 3].rv = (mp == 1) ? 2'b10 : 2'b01;
                    free_at = cyc + 4;
                end
            end
        end
    end

    exp_t e;
    always @(negedge Clock) begin
        if (run_cmp) begin
            if (!Resetn) begin
                check("rst_gnt", Gnt, 0);
                check("rst_rvalid", Rvalid, 0);
                check("rst_rdata", Rdata, 0);
                check("rst_memwren", MemWren, 0);
                check("rst_memaddr", MemAddr, 0);
                check("rst_memdata", MemData, 0);
                check("rst_ledout", LedOut, 0);
            end else if (cyc < DEPTH) begin
                e = exp_q[cyc];
                check("gnt", Gnt, e.gnt);
                check("rvalid", Rvalid, e.rv);
                check("memwren", MemWren, e.wren);
                if (e.wren) begin
                    check("memaddr", MemAddr, e.maddr);
                    check("memdata", MemData, e.mdata);
                end
                check("rdata", Rdata, m_rdata);
                check("ledout", LedOut, m_led);
            end
        end
    end

    int wren_cnt = 0;
    logic [AW-1:0] wren_addr = '0;
    always @(negedge Clock) begin
        if (MemWren === 1'b1) begin
            wren_cnt++;
            wren_addr = MemAddr;
        end
    end

    task automatic issue(input int p, input logic w, input logic [15:0] a,
                         input logic [DW-1:0] d, output int gcyc);
        int n;
        n = 0;
        Req[p] = 1'b1;
        We[p]  = w;
        if (p == 0) begin
            Addr0 = a; Wdata0 = d;
        end else begin
            Addr1 = a; Wdata1 = d;
        end
        do begin
            @(negedge Clock);
            n++;
        end while (Gnt[p] !== 1'b1 && n < 20);
        check($sformatf("gnt_seen_p%0d", p), {31'd0, Gnt[p]}, 1);
        gcyc   = cyc;
        Req[p] = 1'b0;
    endtask

    task automatic bus_write(input int p, input logic [15:0] a, input logic [DW-1:0] d);
        int g;
        issue(p, 1'b1, a, d, g);
        @(negedge Clock);
    endtask

    task automatic bus_read(input int p, input logic [15:0] a,
                            output logic [DW-1:0] q, output int lat);
        int g, n;
        n = 0;
        issue(p, 1'b0, a, '0, g);
        while (Rvalid[p] !== 1'b1 && n < 10) begin
            @(negedge Clock);
            n++;
        end
        check($sformatf("rvalid_seen_p%0d", p), {31'd0, Rvalid[p]}, 1);
        lat = cyc - g;
        q   = Rdata;
        @(negedge Clock);
    endtask

    task automatic do_reset();
        @(posedge Clock);
        #2 Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        @(posedge Clock);
        #2 Resetn = 1'b1;
        @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] q;
        int lat, w0, n, rv_seen;
        int gseq[$];

        Req = 2'b00; We = 2'b00;
        Addr0 = '0; Addr1 = '0; Wdata0 = '0; Wdata1 = '0;
        Resetn = 1'b1;
        #2 Resetn = 1'b0;
        #1 run_cmp = 1'b1;
        repeat (3) @(negedge Clock);
        @(posedge Clock);
        #2 Resetn = 1'b1;
        @(negedge Clock);
        check("reset_ledout_lit", LedOut, 16'h0000);
        check("reset_rdata_lit", Rdata, 16'h0000);

        // Both ports requesting continuously: grants alternate starting with port 0.
        Req = 2'b11; We = 2'b11;
        Addr0 = 16'h0010; Wdata0 = 16'h1111;
        Addr1 = 16'h0011; Wdata1 = 16'h2222;
        n = 0;
        while (gseq.size() < 4 && n < 40) begin
            @(negedge Clock);
            n++;
            if (Gnt[0] === 1'b1) gseq.push_back(0);
            if (Gnt[1] === 1'b1) gseq.push_back(1);
        end
        Req = 2'b00;
        check("rr_grant_count", gseq.size(), 4);
        for (int i = 0; i < gseq.size(); i++)
            check($sformatf("rr_seq_%0d", i), gseq[i], i % 2);
        @(negedge Clock);

        // RAM write then read-back on port 0.
        w0 = wren_cnt;
        bus_write(0, 16'h0005, 16'h00AB);
        check("ram_wr_pulses", wren_cnt - w0, 1);
        check("ram_wr_addr", wren_addr, 7'd5);
        bus_read(0, 16'h0005, q, lat);
        check("ram_rd_data", q, 16'h00AB);
        check("ram_rd_latency", lat, 3);

        // LED register write and read-back on port 1.
        w0 = wren_cnt;
        bus_write(1, 16'h1000, 16'h1234);
        check("led_value", LedOut, 16'h1234);
        check("led_no_wren", wren_cnt - w0, 0);
        bus_read(1, 16'h1000, q, lat);
        check("led_rd_data", q, 16'h1234);
        check("led_rd_latency", lat, 3);

        // Unmapped region: reads return 0, writes go nowhere.
        bus_read(0, 16'hF000, q, lat);
        check("unmapped_rd_data", q, 16'h0000);
        check("unmapped_rd_latency", lat, 3);
        bus_write(0, 16'h0000, 16'h5A5A);
        w0 = wren_cnt;
        bus_write(0, 16'hF000, 16'hBEEF);
        check("unmapped_wr_no_wren", wren_cnt - w0, 0);
        check("unmapped_wr_led", LedOut, 16'h1234);
        bus_read(0, 16'h0000, q, lat);
        check("unmapped_wr_ram", q, 16'h5A5A);

        // Aliasing above the RAM index width.
        bus_write(0, 16'h0085, 16'h0C0D);
        check("alias_wr_addr", wren_addr, 7'd5);
        bus_read(0, 16'h0005, q, lat);
        check("alias_rd_data", q, 16'h0C0D);

        // Reset pulsed during RDWAIT aborts the read.
        issue(0, 1'b0, 16'h0005, '0, lat);
        @(posedge Clock);
        #2 Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        @(posedge Clock);
        #2 Resetn = 1'b1;
        rv_seen = 0;
        repeat (8) begin
            @(negedge Clock);
            if (Rvalid !== 2'b00) rv_seen++;
        end
        check("abort_no_rvalid", rv_seen, 0);
        check("abort_ledout", LedOut, 16'h0000);
        check("abort_rdata", Rdata, 16'h0000);
        Req = 2'b11; We = 2'b00;
        Addr0 = 16'h0005; Addr1 = 16'h1000;
        @(negedge Clock);
        check("abort_first_gnt", Gnt, 2'b01);
        Req = 2'b00;
        repeat (6) @(negedge Clock);

        do_reset();
        check("final_reset_ledout", LedOut, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter `DATA_W`, default 16, bus data width.
REQ-002 The block SHALL have parameter `RAM_AW`, default 7, RAM word-address width.
REQ-003 `Clock`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 `Resetn`, input, 1 bit: reset, asynchronous and active-low.
REQ-005 `Req[1:0]`, input, 2 bits: access request; port 0 is the processor, port 1 is the switch loader.
REQ-006 `We[1:0]`, input, 2 bits: per-port write (1) or read (0).
REQ-007 `Addr0`, `Addr1`, input, 16 bits each: per-port word address.
REQ-008 `Wdata0`, `Wdata1`, input, `DATA_W` bits each: per-port write data.
REQ-009 `Gnt[1:0]`, output, 2 bits: one-cycle acceptance pulse per port.
REQ-010 `Rvalid[1:0]`, output, 2 bits: one-cycle read-data-valid pulse per port.
REQ-011 `Rdata`, output, `DATA_W` bits: read data, shared by both ports, qualified by `Rvalid`.
REQ-012 `MemAddr`, output, `RAM_AW` bits: synchronous RAM address.
REQ-013 `MemWren`, output, 1 bit: synchronous RAM write enable.
REQ-014 `MemData`, output, `DATA_W` bits: synchronous RAM write data.
REQ-015 `MemQ`, input, `DATA_W` bits: RAM read data, valid one clock after the address edge.
REQ-016 `LedOut`, output, `DATA_W` bits: memory-mapped LED output register.

Function
REQ-017 The address decode SHALL be:
- `Addr[15:12]=0`: RAM, index `Addr[RAM_AW-1:0]`.
- `Addr[15:12]=1`: LED register.
- Anything else: unmapped.
REQ-018 The FSM SHALL have states IDLE, ACCESS and RDWAIT, plus a one-cycle registered RETURN phase.
REQ-019 In IDLE with any `Req` set, the block SHALL:
- pick the winner by round-robin;
- register the winner's address, data, We and port id;
- pulse the winner's `Gnt` on the next cycle;
- enter ACCESS.
REQ-020 Round-robin SHALL work as follows:
- If both ports request, the port not granted most recently wins.
- A single requester always wins.
- The pointer updates only on a grant.
REQ-021 In ACCESS, `MemAddr` and `MemData` SHALL be driven from the captured registers. `MemWren` SHALL be 1 only for a RAM-region write.
REQ-022 An LED-region write SHALL update `LedOut` at the end of ACCESS. An unmapped write SHALL be discarded. All writes SHALL return to IDLE after ACCESS (2 cycles total, Req to IDLE).
REQ-023 A RAM read SHALL go ACCESS -> RDWAIT, capture `MemQ` into `Rdata` at the end of RDWAIT, and pulse `Rvalid[port]` the next cycle while returning to IDLE.
REQ-024 An LED-region read SHALL return `LedOut`. An unmapped read SHALL return 0. Both SHALL use the same ACCESS -> RDWAIT timing as a RAM read, so read latency is fixed.
REQ-025 `Rdata` SHALL hold its value until the next read completes.
REQ-026 A requester SHALL hold `Req`, `We`, `Addr` and `Wdata` stable until its `Gnt`. After `Gnt`, it SHALL deassert `Req` or present a new request.
REQ-027 `Req` SHALL be ignored outside IDLE. There SHALL be no queueing, and the losing port waits.
REQ-028 At most one bit of `Gnt` and at most one bit of `Rvalid` SHALL be high in any cycle.
REQ-029 `MemWren` SHALL be 0 in every state other than ACCESS.
REQ-030 RAM address bits above `RAM_AW` within the RAM region SHALL be ignored, so accesses alias.

Reset
REQ-031 While `Resetn=0`, the block SHALL hold:
- FSM in IDLE;
- `Gnt=0`, `Rvalid=0`, `Rdata=0`;
- `MemWren=0`, `MemAddr=0`, `MemData=0`;
- `LedOut=0`;
- round-robin pointer favouring port 0.
REQ-032 A reset asserted mid-transaction SHALL abort it with no `Gnt`, `Rvalid` or write issued afterwards. A RAM write in progress in ACCESS SHALL be cut off asynchronously.

Structure
REQ-033 A shared package `mem_bus_pkg` SHALL hold:
- the FSM state encoding;
- region decode constants (RAM=4'h0, LED=4'h1);
- the default widths.
REQ-034 The two-input round-robin selection SHALL be a sub-module `rr_pick2`, with inputs `req[1:0]` and `ptr`, and outputs a one-hot grant and the next pointer.

Verification
REQ-035 After reset, port 0 writes 16'h00AB to 16'h0005 and then reads it back -> `MemWren` is high for 1 cycle with `MemAddr=5`, and `Rvalid[0]` pulses 3 cycles after Gnt with `Rdata=16'h00AB`.
REQ-036 Both ports request continuously -> grants alternate 0,1,0,1, and neither port is starved.
REQ-037 Port 1 writes 16'h1234 to 16'h1000 -> `LedOut=16'h1234`, `MemWren` never asserted; a read of 16'h1000 then returns 16'h1234.
REQ-038 Port 0 reads unmapped 16'hF000 -> `Rvalid[0]` pulses with `Rdata=0`; a write to 16'hF000 changes neither RAM nor `LedOut`.
REQ-039 Port 0 writes 16'h0085 then reads 16'h0005 -> the same RAM word is returned (alias).
REQ-040 `Resetn` pulsed low during RDWAIT -> no `Rvalid`, FSM in IDLE, `LedOut=0`, and the next simultaneous request grants port 0 first.
